// File: rtl/icache.sv
// N-way set-associative instruction cache: one outstanding fetch, single-beat line refill,
// invalid-first / round-robin replacement and a set-per-cycle flush for fence.i.
module icache #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned NUM_WAYS   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_instr,
    output logic                    resp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_data,
    input  logic                    flush,
    output logic                    flush_busy
);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MISS_REQ  = 3'd1,
        MISS_WAIT = 3'd2,
        RESP      = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;
    logic                r_pend, w_pend_nxt;
    logic [IDX_W-1:0]    r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [WAY_W-1:0]    r_victim, w_victim_nxt;
    logic                r_req_ready, w_req_ready_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic [31:0]         r_resp_instr, w_resp_instr_nxt;
    logic                r_resp_err, w_resp_err_nxt;
    logic                r_mem_req_valid, w_mem_req_valid_nxt;
    logic [ADDR_W-1:0]   r_mem_req_addr, w_mem_req_addr_nxt;
    logic                r_flush_busy, w_flush_busy_nxt;
    logic                w_fill, w_flush_clr;

    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [WAY_W-1:0]    r_rr    [NUM_SETS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]    w_req_idx, w_fill_idx;
    logic [TAG_W-1:0]    w_req_tag, w_fill_tag;
    logic                w_hit, w_inv_found;
    logic [WAY_W-1:0]    w_hit_way, w_victim;
    logic [WAY_W-1:0]    w_rr_adv;

    // Select the 32-bit word addressed by a byte offset within a line
    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                              input logic [OFF_W-1:0]  off);
        logic [OFF_W-1:0] aligned;
        aligned = off & ~OFF_W'(3);
        return 32'(line >> {aligned, 3'b000});
    endfunction

    assign w_req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign w_req_tag  = req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign w_fill_idx = r_addr[OFF_W+IDX_W-1:OFF_W];
    assign w_fill_tag = r_addr[ADDR_W-1:OFF_W+IDX_W];
    assign w_rr_adv   = (r_rr[w_fill_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                    : r_rr[w_fill_idx] + WAY_W'(1);

    // Tag lookup and victim choice for the incoming request
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_victim    = r_rr[w_req_idx];
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!w_hit && r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_inv_found && !r_valid[w_req_idx][w]) begin
                w_inv_found = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_pend_nxt          = r_pend;
        w_cnt_nxt           = r_cnt;
        w_addr_nxt          = r_addr;
        w_victim_nxt        = r_victim;
        w_resp_valid_nxt    = r_resp_valid;
        w_resp_instr_nxt    = r_resp_instr;
        w_resp_err_nxt      = r_resp_err;
        w_mem_req_valid_nxt = r_mem_req_valid;
        w_mem_req_addr_nxt  = r_mem_req_addr;
        w_fill              = 1'b0;
        w_flush_clr         = 1'b0;

        case (r_state)
            IDLE: begin
                if (flush || r_pend) begin
                    w_state_nxt = FLUSH;
                    w_pend_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (req_valid) begin
                    w_addr_nxt = req_addr;
                    if (req_addr[1:0] != 2'b00) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_instr_nxt = '0;
                        w_state_nxt      = RESP;
                    end else if (w_hit) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b0;
                        w_resp_instr_nxt = pick_word(r_data[w_req_idx][w_hit_way],
                                                     req_addr[OFF_W-1:0]);
                        w_state_nxt      = RESP;
                    end else begin
                        w_victim_nxt        = w_victim;
                        w_mem_req_valid_nxt = 1'b1;
                        w_mem_req_addr_nxt  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        w_state_nxt         = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                if (flush) w_pend_nxt = 1'b1;
                if (mem_req_ready) begin
                    w_mem_req_valid_nxt = 1'b0;
                    w_state_nxt         = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (flush) w_pend_nxt = 1'b1;
                if (mem_resp_valid) begin
                    w_fill           = 1'b1;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_instr_nxt = pick_word(mem_resp_data, r_addr[OFF_W-1:0]);
                    w_state_nxt      = RESP;
                end
            end
            RESP: begin
                if (flush) w_pend_nxt = 1'b1;
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    if (flush || r_pend) begin
                        w_state_nxt = FLUSH;
                        w_pend_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                w_flush_clr = 1'b1;
                w_cnt_nxt   = r_cnt + IDX_W'(1);
                if (r_cnt == IDX_W'(NUM_SETS - 1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_req_ready_nxt  = (w_state_nxt == IDLE) && !w_pend_nxt;
        w_flush_busy_nxt = w_pend_nxt || (w_state_nxt == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_pend          <= 1'b0;
            r_cnt           <= '0;
            r_addr          <= '0;
            r_victim        <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_instr    <= '0;
            r_resp_err      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_flush_busy    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pend          <= w_pend_nxt;
            r_cnt           <= w_cnt_nxt;
            r_addr          <= w_addr_nxt;
            r_victim        <= w_victim_nxt;
            r_req_ready     <= w_req_ready_nxt;
            r_resp_valid    <= w_resp_valid_nxt;
            r_resp_instr    <= w_resp_instr_nxt;
            r_resp_err      <= w_resp_err_nxt;
            r_mem_req_valid <= w_mem_req_valid_nxt;
            r_mem_req_addr  <= w_mem_req_addr_nxt;
            r_flush_busy    <= w_flush_busy_nxt;
        end
    end

    // Valid bits and replacement pointers: cleared by reset and by the flush walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (w_flush_clr) begin
            r_valid[r_cnt] <= '0;
            r_rr[r_cnt]    <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_idx][r_victim] <= 1'b1;
            r_rr[w_fill_idx]              <= w_rr_adv;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx][r_victim]  <= w_fill_tag;
            r_data[w_fill_idx][r_victim] <= mem_resp_data;
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_instr    = r_resp_instr;
    assign resp_err      = r_resp_err;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign flush_busy    = r_flush_busy;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: miss/hit, eviction order, misalignment, backpressure, flush and reset.
module tb_icache;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_instr;
    logic         resp_err;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [63:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         flush;
    logic         flush_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_instr    (resp_instr),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .flush         (flush),
        .flush_busy    (flush_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory contents: word i of the line at A is {A[31:16]^C0DE, A[15:0]+4i},
    // so any aligned fetch address A returns A[31:0] ^ 32'hC0DE0000.
    function automatic logic [127:0] line_of(input logic [63:0] a);
        logic [127:0] l;
        logic [63:0]  base;
        base = a & ~64'hF;
        for (int i = 0; i < 4; i++)
            l[i*32 +: 32] = {base[31:16] ^ 16'hC0DE, base[15:0] + 16'(i * 4)};
        return l;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"},    64'(resp_valid),    64'd0);
        check({tag, "_resp_instr"},    64'(resp_instr),    64'd0);
        check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_mem_req_addr"},  mem_req_addr,       64'd0);
        check({tag, "_flush_busy"},    64'(flush_busy),    64'd0);
        check({tag, "_req_ready"},     64'(req_ready),     64'd1);
    endtask

    // Issue a fetch, serve a miss if one appears, then drain the response
    task automatic fetch(input string tag, input logic [63:0] a, input bit exp_miss,
                         input logic [31:0] exp_instr, input bit exp_err,
                         input int req_stall, input int resp_stall);
        bit seen_mreq;
        @(negedge clk);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        seen_mreq = mem_req_valid;
        if (mem_req_valid) begin
            check({tag, "_mreq_addr"}, mem_req_addr, a & ~64'hF);
            for (int i = 0; i < req_stall; i++) begin
                @(negedge clk);
                check({tag, "_mreq_hold"}, {63'(mem_req_addr), mem_req_valid},
                      {63'(a & ~64'hF), 1'b1});
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = line_of(a);
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
        check({tag, "_miss"},       64'(seen_mreq),  64'(exp_miss));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_resp_instr"}, 64'(resp_instr), 64'(exp_instr));
        check({tag, "_resp_err"},   64'(resp_err),   64'(exp_err));
        for (int i = 0; i < resp_stall; i++) begin
            @(negedge clk);
            check({tag, "_resp_hold"}, {30'd0, req_ready, resp_valid, resp_instr},
                  {30'd0, 1'b0, 1'b1, exp_instr});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_resp_done"}, {62'd0, resp_valid, req_ready}, 64'd1);
    endtask

    initial begin
        int n_busy;
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = '0;
        resp_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        flush          = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        fetch("m0",  64'h8000_0000, 1'b1, 32'h40DE_0000, 1'b0, 0, 0);
        fetch("h0",  64'h8000_000C, 1'b0, 32'h40DE_000C, 1'b0, 0, 0);

        fetch("ev0", 64'h0000_0000, 1'b1, 32'hC0DE_0000, 1'b0, 0, 0);
        fetch("ev1", 64'h0000_1000, 1'b1, 32'hC0DE_1000, 1'b0, 0, 0);
        fetch("ev2", 64'h0000_2000, 1'b1, 32'hC0DE_2000, 1'b0, 0, 0);
        fetch("ev3", 64'h0000_1004, 1'b0, 32'hC0DE_1004, 1'b0, 0, 0);
        fetch("ev4", 64'h0000_0008, 1'b1, 32'hC0DE_0008, 1'b0, 0, 0);

        fetch("mis", 64'h8000_0002, 1'b0, 32'h0000_0000, 1'b1, 0, 0);

        fetch("bp",  64'h8000_0040, 1'b1, 32'h40DE_0040, 1'b0, 5, 4);
        fetch("bph", 64'h8000_0044, 1'b0, 32'h40DE_0044, 1'b0, 0, 0);

        // Flush raised while the fill is outstanding
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 64'h0000_4440;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_busy_pend", 64'(flush_busy), 64'd1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_of(64'h0000_4440);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("fl_resp", {31'd0, resp_valid, resp_instr}, {31'd0, 1'b1, 32'hC0DE_4440});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_busy = 0;
        while (flush_busy && n_busy < 400) begin
            n_busy++;
            @(negedge clk);
        end
        check("fl_cycles", 64'(n_busy), 64'd256);
        fetch("fl_re", 64'h0000_4440, 1'b1, 32'hC0DE_4440, 1'b0, 0, 0);

        // Reset during MISS_WAIT; the late fill must be ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 64'h0000_5550;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        check_reset_outputs("mrst");
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_of(64'h0000_5550);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("mrst_late", {62'd0, resp_valid, req_ready}, 64'd1);
        fetch("mrst_re", 64'h0000_5550, 1'b1, 32'hC0DE_5550, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Parametrised N-way set-associative instruction cache sitting between the PC stage and instruction memory. Successor to the single-cycle fetch cache: configurable geometry, a true multi-cycle memory refill handshake, valid/ready on both sides, invalid-first plus round-robin replacement, misalignment reporting, and a sequential flush for `fence.i`.

## Interface
- `ADDR_W`, 64: address width.
- `LINE_BYTES`, 16: bytes per line, power of 2, ≥4; `OFF_W = log2(LINE_BYTES)`.
- `NUM_SETS`, 256: sets, power of 2; `IDX_W = log2(NUM_SETS)`; tag = `ADDR_W-IDX_W-OFF_W` bits.
- `NUM_WAYS`, 2: ways, power of 2, 1..8.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: fetch request.
- `req_ready` out 1: request can be accepted.
- `req_addr` in ADDR_W: fetch PC.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes response.
- `resp_instr` out 32: instruction word.
- `resp_err` out 1: misaligned PC; `resp_instr` = 0.
- `mem_req_valid` out 1: line-fill request.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_addr` out ADDR_W: line-aligned address, low `OFF_W` bits = 0.
- `mem_resp_valid` in 1: fill data present, single beat.
- `mem_resp_data` in LINE_BYTES*8: line, byte 0 in bits [7:0].
- `flush` in 1: invalidate all lines, pulse or level.
- `flush_busy` out 1: flush pending or in progress.

## Operation
- States: IDLE, MISS_REQ, MISS_WAIT, RESP, FLUSH.
- IDLE: `req_ready` = 1 unless flush pending. Flush pending/asserted in IDLE beats `req_valid` and enters FLUSH; no request is accepted that cycle.
- Accept (`req_valid && req_ready`):
  - `req_addr[1:0] != 0`: `resp_err` = 1, go RESP, no memory access.
  - Hit in any valid way with a matching tag: word `req_addr[OFF_W-1:2]` of that line goes to `resp_instr`, go RESP.
  - Miss: latch address and victim, go MISS_REQ.
- Victim: lowest-index invalid way, else the per-set round-robin pointer. The pointer advances (mod NUM_WAYS) on every fill of its set.
- MISS_REQ: `mem_req_valid` = 1, held with a stable address until `mem_req_ready`, then MISS_WAIT.
- MISS_WAIT: on `mem_resp_valid`, write data, tag and valid = 1 into the victim, capture the requested word, go RESP. `mem_resp_valid` outside MISS_WAIT is ignored.
- RESP: `resp_valid` = 1 and outputs stable until `resp_ready`, then IDLE. Never more than one request outstanding.
- FLUSH: an `IDX_W`-bit counter clears all ways' valid bits of one set per cycle, for NUM_SETS cycles, then IDLE. Round-robin pointers are reset to 0.
- `flush` in MISS_*/RESP is latched pending. The current request completes normally, including its fill, and FLUSH follows.
- `flush_busy` = pending | state==FLUSH.
- Tags and data are not reset; valid bits, pointers and the FSM are.

## Timing
- Reset (async assert, any state): IDLE, all valid = 0, pointers = 0, flush pending = 0, `req_ready` = 1. All other outputs (`resp_valid`, `resp_instr`, `resp_err`, `mem_req_valid`, `mem_req_addr`, `flush_busy`) = 0. An in-flight miss is abandoned; its late memory response is ignored.
- Hit or misaligned: accepted at edge N, `resp_valid` high from edge N.
- Miss: accepted at edge N, `mem_req_valid` from N. Handshake at edge M, then MISS_WAIT. `mem_resp_valid` sampled at edge K; `resp_valid` from K. Minimum accept-to-response is 3 edges with zero-latency memory.
- `resp_ready` sampled at edge R: `req_ready` high from R. Back-to-back hits give one response per 2 cycles.
- Flush: `flush_busy` high from the sampling edge; FLUSH lasts exactly NUM_SETS cycles.

## Test plan
- Reset, then fetch 0x80000000 → miss; `mem_req_addr` = 0x80000000. Memory returns words {W3,W2,W1,W0}, so `resp_instr` = W0. Then fetch 0x8000000C → hit with `resp_instr` = W3, 1-cycle latency, no `mem_req_valid`.
- Default geometry: fill 0x0000, 0x1000, 0x2000 (same set 0). The third fill evicts way 0 (0x0000). Refetch 0x1000 hits; refetch 0x0000 misses.
- Fetch 0x80000002 → `resp_err` = 1, `resp_instr` = 0, `mem_req_valid` never asserted.
- Backpressure: hold `mem_req_ready` = 0 for 5 cycles → `mem_req_valid` and address stable. Hold `resp_ready` = 0 for 4 cycles → response stable, `req_ready` = 0.
- Assert `flush` during MISS_WAIT → the response is still delivered. Then `flush_busy` lasts 256 cycles, and refetching the just-filled line misses.
- Assert `rst_n` low during MISS_WAIT, then deliver `mem_resp_valid` after release → ignored. Outputs are at reset values and the next fetch of the same line misses.
